pr_hrav_result_arbiter: RTL and testbench

- Packet-granular arbiter that shares the single TX DMA stream (to S/W via PCIe EP) between three requesters: scanner core 0 results, scanner core 1 results, and ICAP controller status.
- Sits on the return path opposite the dispatcher. Packets are forwarded unmodified, whole and never interleaved.
- Supports round-robin arbitration, or strict ICAP priority when configured.

---
 rtl/pr_hrav_result_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_pr_hrav_result_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_hrav_result_arbiter.sv
// Packet-granular arbiter merging core0, core1 and ICAP result streams onto one TX DMA stream.
// Optional HRAV_ARB_SRC_TAG_EN overwrites TUSER[23:16] with a per-source tag.
module pr_hrav_result_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int ICAP_PRIO           = 0,
  parameter int CNT_W               = 16
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     CORE0_S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   CORE0_S_AXIS_TSTRB,
  input  logic [127:0]                       CORE0_S_AXIS_TUSER,
  input  logic                               CORE0_S_AXIS_TVALID,
  input  logic                               CORE0_S_AXIS_TLAST,
  output logic                               CORE0_S_AXIS_TREADY,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     CORE1_S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   CORE1_S_AXIS_TSTRB,
  input  logic [127:0]                       CORE1_S_AXIS_TUSER,
  input  logic                               CORE1_S_AXIS_TVALID,
  input  logic                               CORE1_S_AXIS_TLAST,
  output logic                               CORE1_S_AXIS_TREADY,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     ICAP_S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   ICAP_S_AXIS_TSTRB,
  input  logic [127:0]                       ICAP_S_AXIS_TUSER,
  input  logic                               ICAP_S_AXIS_TVALID,
  input  logic                               ICAP_S_AXIS_TLAST,
  output logic                               ICAP_S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic [127:0]                       M_AXIS_TUSER,
  output logic                               M_AXIS_TVALID,
  output logic                               M_AXIS_TLAST,
  input  logic                               M_AXIS_TREADY,
  output logic [3*CNT_W-1:0]                 PKT_CNT,
  output logic [2:0]                         GRANT
);

  typedef enum logic [1:0] {IDLE, GNT_CORE0, GNT_CORE1, GNT_ICAP} state_t;

  state_t                            state;
  logic [1:0]                        rr_ptr;
  logic [2:0]                        grant_q;
  logic [CNT_W-1:0]                  cnt [3];

  logic [C_M_AXIS_DATA_WIDTH-1:0]    data_p0;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  strb_p0;
  logic [127:0]                      user_p0;
  logic                              last_p0;
  logic                              vld_p0;

  logic [C_S_AXIS_DATA_WIDTH-1:0]    sel_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  sel_strb;
  logic [127:0]                      sel_user;
  logic [127:0]                      out_user;
  logic                              sel_valid;
  logic                              sel_last;
  logic                              out_ready;
  logic                              accept;
  logic [1:0]                        cur_src;
  logic [1:0]                        win;
  logic [2:0]                        req;

  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 2'd3;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

`ifdef HRAV_ARB_SRC_TAG_EN
  function automatic logic [127:0] tag_user(input logic [127:0] u, input logic [1:0] src);
    tag_user = u;
    case (src)
      2'd0:    tag_user[23:16] = 8'h01;
      2'd1:    tag_user[23:16] = 8'h04;
      default: tag_user[23:16] = 8'h10;
    endcase
  endfunction

  assign out_user = tag_user(sel_user, cur_src);
`else
  assign out_user = sel_user;
`endif

  assign req       = {ICAP_S_AXIS_TVALID, CORE1_S_AXIS_TVALID, CORE0_S_AXIS_TVALID};
  assign cur_src   = state - 2'd1;
  assign out_ready = ~vld_p0 | M_AXIS_TREADY;
  assign accept    = sel_valid & out_ready & ~ARESET;

  // Ready is withheld during reset so no beat can slip into a discarded cycle.
  assign CORE0_S_AXIS_TREADY = grant_q[0] & out_ready & ~ARESET;
  assign CORE1_S_AXIS_TREADY = grant_q[1] & out_ready & ~ARESET;
  assign ICAP_S_AXIS_TREADY  = grant_q[2] & out_ready & ~ARESET;

  always_comb begin
    win = rr_pick(req, rr_ptr);
    if (ICAP_PRIO != 0 && req[2]) win = 2'd2;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_user  = '0;
    sel_last  = 1'b0;
    case (state)
      GNT_CORE0: begin
        sel_valid = CORE0_S_AXIS_TVALID;
        sel_data  = CORE0_S_AXIS_TDATA;
        sel_strb  = CORE0_S_AXIS_TSTRB;
        sel_user  = CORE0_S_AXIS_TUSER;
        sel_last  = CORE0_S_AXIS_TLAST;
      end
      GNT_CORE1: begin
        sel_valid = CORE1_S_AXIS_TVALID;
        sel_data  = CORE1_S_AXIS_TDATA;
        sel_strb  = CORE1_S_AXIS_TSTRB;
        sel_user  = CORE1_S_AXIS_TUSER;
        sel_last  = CORE1_S_AXIS_TLAST;
      end
      GNT_ICAP: begin
        sel_valid = ICAP_S_AXIS_TVALID;
        sel_data  = ICAP_S_AXIS_TDATA;
        sel_strb  = ICAP_S_AXIS_TSTRB;
        sel_user  = ICAP_S_AXIS_TUSER;
        sel_last  = ICAP_S_AXIS_TLAST;
      end
      default: ;
    endcase
  end

  // Arbitration FSM and per-source packet counters.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      rr_ptr  <= 2'd0;
      grant_q <= 3'b000;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win != 2'd3) begin
            state   <= state_t'(win + 2'd1);
            grant_q <= 3'b001 << win;
          end
        end
        default: begin
          if (accept && sel_last) begin
            state   <= IDLE;
            grant_q <= 3'b000;
            rr_ptr  <= (cur_src == 2'd2) ? 2'd0 : cur_src + 2'd1;
            for (int k = 0; k < 3; k++)
              if (cur_src == 2'(k)) cnt[k] <= cnt[k] + 1'b1;
          end
        end
      endcase
    end
  end

  // Stage p0: single output register toward TX DMA.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      strb_p0 <= '0;
      user_p0 <= '0;
      last_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      data_p0 <= sel_data;
      strb_p0 <= sel_strb;
      user_p0 <= out_user;
      last_p0 <= sel_last;
    end else if (M_AXIS_TREADY) begin
      vld_p0  <= 1'b0;
    end
  end

  assign M_AXIS_TDATA  = data_p0;
  assign M_AXIS_TSTRB  = strb_p0;
  assign M_AXIS_TUSER  = user_p0;
  assign M_AXIS_TLAST  = last_p0;
  assign M_AXIS_TVALID = vld_p0;
  assign GRANT         = grant_q;
  assign PKT_CNT       = {cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_pr_hrav_result_arbiter.sv
// Bench for pr_hrav_result_arbiter: instance 0 round-robin, instance 1 with ICAP priority.
module tb_pr_hrav_result_arbiter;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  st;
    logic [127:0] u;
    logic         l;
  } sb_t;

  logic         ACLK = 1'b0;
  logic         rst [2];
  logic [255:0] s_tdata  [2][3];
  logic [31:0]  s_tstrb  [2][3];
  logic [127:0] s_tuser  [2][3];
  logic         s_tvalid [2][3];
  logic         s_tlast  [2][3];
  logic         s_tready [2][3];
  logic [255:0] m_tdata  [2];
  logic [31:0]  m_tstrb  [2];
  logic [127:0] m_tuser  [2];
  logic         m_tvalid [2];
  logic         m_tlast  [2];
  logic         m_tready [2];
  logic [47:0]  pkt_cnt  [2];
  logic [2:0]   grant    [2];

  bit           hs [2][3];
  bit           sb_en [2];
  bit           prev_acc [2];
  bit           prev_stall [2];
  logic [255:0] prev_data [2];
  bit           gap_en = 0;
  int           idle_cnt = 0;
  int           total = 0;
  int           bad = 0;
  sb_t          q0 [$];
  sb_t          q1 [$];

  always #5 ACLK = ~ACLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pr_hrav_result_arbiter #(.ICAP_PRIO(g)) dut (
      .ACLK(ACLK), .ARESET(rst[g]),
      .CORE0_S_AXIS_TDATA(s_tdata[g][0]), .CORE0_S_AXIS_TSTRB(s_tstrb[g][0]),
      .CORE0_S_AXIS_TUSER(s_tuser[g][0]), .CORE0_S_AXIS_TVALID(s_tvalid[g][0]),
      .CORE0_S_AXIS_TLAST(s_tlast[g][0]), .CORE0_S_AXIS_TREADY(s_tready[g][0]),
      .CORE1_S_AXIS_TDATA(s_tdata[g][1]), .CORE1_S_AXIS_TSTRB(s_tstrb[g][1]),
      .CORE1_S_AXIS_TUSER(s_tuser[g][1]), .CORE1_S_AXIS_TVALID(s_tvalid[g][1]),
      .CORE1_S_AXIS_TLAST(s_tlast[g][1]), .CORE1_S_AXIS_TREADY(s_tready[g][1]),
      .ICAP_S_AXIS_TDATA(s_tdata[g][2]), .ICAP_S_AXIS_TSTRB(s_tstrb[g][2]),
      .ICAP_S_AXIS_TUSER(s_tuser[g][2]), .ICAP_S_AXIS_TVALID(s_tvalid[g][2]),
      .ICAP_S_AXIS_TLAST(s_tlast[g][2]), .ICAP_S_AXIS_TREADY(s_tready[g][2]),
      .M_AXIS_TDATA(m_tdata[g]), .M_AXIS_TSTRB(m_tstrb[g]), .M_AXIS_TUSER(m_tuser[g]),
      .M_AXIS_TVALID(m_tvalid[g]), .M_AXIS_TLAST(m_tlast[g]), .M_AXIS_TREADY(m_tready[g]),
      .PKT_CNT(pkt_cnt[g]), .GRANT(grant[g])
    );
  end

  function automatic logic [255:0] mk_data(input logic [7:0] id, input int b);
    return {8{id, 8'(b), 16'hA5C3}};
  endfunction
  function automatic logic [31:0] mk_strb(input logic [7:0] id, input int b);
    return {id, 8'(b), 16'h0F0F};
  endfunction
  // Every beat carries 8'hFF in TUSER[23:16] so the src-port field is always exercised.
  function automatic logic [127:0] mk_user(input logic [7:0] id, input int b);
    return {4{id, 8'hFF, 8'(b), 8'h3C}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, got no event expected one", nm);
  endtask

  task automatic push_pkt(input int i, input int s, input int n, input logic [7:0] id);
    sb_t e;
    for (int b = 0; b < n; b++) begin
      e.d  = mk_data(id, b);
      e.st = mk_strb(id, b);
      e.u  = mk_user(id, b);
`ifdef HRAV_ARB_SRC_TAG_EN
      e.u[23:16] = (s == 0) ? 8'h01 : (s == 1) ? 8'h04 : 8'h10;
`endif
      e.l  = (b == n - 1);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic set_beat(input int i, input int s, input int b, input int n, input logic [7:0] id);
    s_tdata[i][s]  = mk_data(id, b);
    s_tstrb[i][s]  = mk_strb(id, b);
    s_tuser[i][s]  = mk_user(id, b);
    s_tlast[i][s]  = (b == n - 1);
    s_tvalid[i][s] = 1'b1;
  endtask

  task automatic wait_hs(input int i, input int s);
    int c = 0;
    do begin
      @(negedge ACLK);
      c++;
    end while (!hs[i][s] && c < 300);
    if (!hs[i][s]) timeout("src_handshake");
  endtask

  task automatic wait_grant(input int i, input logic [2:0] val);
    int c = 0;
    while (grant[i] !== val && c < 300) begin
      @(negedge ACLK);
      c++;
    end
    if (grant[i] !== val) timeout("wait_grant");
  endtask

  task automatic send(input int i, input int s, input int n, input logic [7:0] id);
    for (int b = 0; b < n; b++) begin
      set_beat(i, s, b, n, id);
      wait_hs(i, s);
    end
    s_tvalid[i][s] = 1'b0;
    s_tlast[i][s]  = 1'b0;
  endtask

  task automatic do_reset(input int i);
    @(negedge ACLK);
    rst[i] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      s_tvalid[i][s] = 1'b0;
      s_tlast[i][s]  = 1'b0;
    end
    repeat (2) @(negedge ACLK);
    rst[i] = 1'b0;
    chk("rst_m_tvalid", m_tvalid[i], 0);
    chk("rst_grant", grant[i], 0);
    chk("rst_pkt_cnt", pkt_cnt[i], 0);
    chk("rst_s_tready", {s_tready[i][2], s_tready[i][1], s_tready[i][0]}, 0);
    chk("rst_m_tdata", m_tdata[i], 0);
    chk("rst_m_tlast", m_tlast[i], 0);
  endtask

  task automatic pop_cmp(input int i);
    sb_t e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_beat inst%0d: got data %0h expected no beat", i, m_tdata[i]);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk("out_tdata", m_tdata[i], e.d);
    chk("out_tstrb", m_tstrb[i], e.st);
    chk("out_tuser", m_tuser[i], e.u);
    chk("out_tlast", m_tlast[i], e.l);
  endtask

  // Monitor: samples 1 time unit before each rising edge, after stimulus has settled.
  initial forever begin
    bit acc;
    @(negedge ACLK);
    #4;
    for (int i = 0; i < 2; i++) begin
      if (prev_acc[i] && !rst[i]) chk("latency_vld", m_tvalid[i], 1);
      if (prev_stall[i] && !rst[i]) begin
        chk("stall_data", m_tdata[i], prev_data[i]);
        chk("stall_vld", m_tvalid[i], 1);
      end
      if (!rst[i] && m_tvalid[i] && !m_tready[i])
        chk("stall_s_tready", {s_tready[i][2], s_tready[i][1], s_tready[i][0]}, 0);
      if (!rst[i] && m_tvalid[i] && m_tready[i] && sb_en[i]) pop_cmp(i);
      acc = 0;
      for (int s = 0; s < 3; s++) begin
        hs[i][s] = s_tvalid[i][s] && s_tready[i][s];
        acc |= hs[i][s];
      end
      prev_acc[i]   = acc && !rst[i];
      prev_stall[i] = !rst[i] && m_tvalid[i] && !m_tready[i];
      prev_data[i]  = m_tdata[i];
    end
    if (gap_en && grant[0] == 3'b000 && (s_tvalid[0][0] || s_tvalid[0][1] || s_tvalid[0][2]))
      idle_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat [4] = '{1, 0, 0, 1};
    bit done;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      m_tready[i] = 1'b1;
      sb_en[i] = 1'b1;
      for (int s = 0; s < 3; s++) begin
        s_tdata[i][s] = '0; s_tstrb[i][s] = '0; s_tuser[i][s] = '0;
        s_tvalid[i][s] = 1'b0; s_tlast[i][s] = 1'b0;
      end
    end
    do_reset(0);
    do_reset(1);

    // Single 4-beat core0 packet.
    push_pkt(0, 0, 4, 8'h11);
    fork
      send(0, 0, 4, 8'h11);
      begin
        @(negedge ACLK);
        chk("t1_grant_core0", grant[0], 3'b001);
      end
    join
    chk("t1_grant_idle", grant[0], 3'b000);
    chk("t1_cnt_core0", pkt_cnt[0][15:0], 1);
    repeat (3) @(negedge ACLK);

    // Three simultaneous 2-beat packets, round-robin order.
    do_reset(0);
    push_pkt(0, 0, 2, 8'h21);
    push_pkt(0, 1, 2, 8'h22);
    push_pkt(0, 2, 2, 8'h23);
    idle_cnt = 0;
    gap_en = 1;
    fork
      send(0, 0, 2, 8'h21);
      send(0, 1, 2, 8'h22);
      send(0, 2, 2, 8'h23);
    join
    gap_en = 0;
    repeat (3) @(negedge ACLK);
    chk("t2_idle_gaps", idle_cnt, 3);
    chk("t2_pkt_cnt", pkt_cnt[0], {16'd1, 16'd1, 16'd1});

    // ICAP priority instance.
    do_reset(1);
    push_pkt(1, 2, 1, 8'h31);
    push_pkt(1, 0, 2, 8'h32);
    push_pkt(1, 2, 1, 8'h33);
    push_pkt(1, 1, 1, 8'h34);
    fork
      send(1, 0, 2, 8'h32);
      begin
        send(1, 2, 1, 8'h31);
        wait_grant(1, 3'b001);
        send(1, 2, 1, 8'h33);
      end
      begin
        wait_grant(1, 3'b001);
        send(1, 1, 1, 8'h34);
      end
      begin
        @(negedge ACLK);
        chk("t3_first_grant_icap", grant[1], 3'b100);
      end
    join
    repeat (3) @(negedge ACLK);
    chk("t3_pkt_cnt", pkt_cnt[1], {16'd2, 16'd1, 16'd1});

    // Backpressure during a 3-beat core1 packet.
    do_reset(0);
    push_pkt(0, 1, 3, 8'h41);
    done = 0;
    fork
      begin
        send(0, 1, 3, 8'h41);
        done = 1;
      end
      begin
        int k = 0;
        while (!done) begin
          m_tready[0] = pat[k % 4][0];
          @(negedge ACLK);
          k++;
        end
      end
    join
    m_tready[0] = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("t4_cnt_core1", pkt_cnt[0][31:16], 1);

    // Reset on beat 2 of a 5-beat core0 packet.
    do_reset(0);
    sb_en[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      set_beat(0, 0, b, 5, 8'h51);
      wait_hs(0, 0);
    end
    rst[0] = 1'b1;
    @(negedge ACLK);
    chk("t5_m_tvalid", m_tvalid[0], 0);
    chk("t5_grant", grant[0], 0);
    chk("t5_s_tready", {s_tready[0][2], s_tready[0][1], s_tready[0][0]}, 0);
    chk("t5_pkt_cnt", pkt_cnt[0], 0);
    s_tvalid[0][0] = 1'b0;
    s_tlast[0][0]  = 1'b0;
    rst[0] = 1'b0;
    @(negedge ACLK);
    sb_en[0] = 1'b1;
    push_pkt(0, 0, 2, 8'h52);
    send(0, 0, 2, 8'h52);
    repeat (3) @(negedge ACLK);
    chk("t5_cnt_after", pkt_cnt[0], {16'd0, 16'd0, 16'd1});

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
